// File: rtl/led_feed_pkg.sv
// Shared definitions for the LED frame feeder: register map, pixel width, FSM states.
package led_feed_pkg;

    localparam int LED_PIX_W = 24;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_LEN    = 8'h08;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_AUTO_BIT  = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_FRONT_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } feed_state_t;

    // Frame length as written by software, clamped to the buffer depth.
    function automatic logic [6:0] sat_len(input logic [31:0] wdata, input int max_len);
        if (wdata > 32'(max_len)) begin
            return 7'(max_len);
        end
        return wdata[6:0];
    endfunction

endpackage

// File: rtl/led_pixel_bank.sv
// Register-array pixel store: one APB write port, one APB read port, one stream read port.
module led_pixel_bank
    import led_feed_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PIX_W = LED_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [5:0]       i_waddr,
    input  logic [PIX_W-1:0] i_wdata,
    input  logic [5:0]       i_raddr,
    output logic [PIX_W-1:0] o_rdata,
    input  logic [5:0]       i_saddr,
    output logic [PIX_W-1:0] o_sdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic             w_raddr_ok;
    logic             w_saddr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_we && ({1'b0, i_waddr} == 7'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Indices past the configured depth read back as zero.
    assign w_raddr_ok = ({1'b0, i_raddr} < 7'(DEPTH));
    assign w_saddr_ok = ({1'b0, i_saddr} < 7'(DEPTH));
    assign o_rdata    = w_raddr_ok ? r_mem[i_raddr[AW-1:0]] : '0;
    assign o_sdata    = w_saddr_ok ? r_mem[i_saddr[AW-1:0]] : '0;

endmodule

// File: rtl/led_frame_feeder.sv
// APB3 frame buffer streaming GRB pixels over valid/ready, then holding the WS2812 latch gap.
// Define LED_FEED_DOUBLE_BUF_EN for a second bank that swaps with the stream at each frame start.
module led_frame_feeder
    import led_feed_pkg::*;
#(
    parameter int NUM_PIXELS = 8,
    parameter int GAP_CYCLES = 5000,
    parameter int PIX_W      = LED_PIX_W
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [31:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    output logic [PIX_W-1:0] px_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             px_last,
    output logic             frame_done
);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    logic             w_apb_wr;
    logic             w_apb_rd;
    logic             w_pix_we;
    logic             w_wr_ctrl;
    logic             w_wr_status;
    logic             w_wr_len;
    logic             w_start_req;
    logic             w_gap_end;
    logic             w_frame_start;
    logic             w_front;
    logic [5:0]       w_s_addr;
    logic [PIX_W-1:0] w_apb_rdata;
    logic [PIX_W-1:0] w_s_front;
    logic [PIX_W-1:0] w_s_start;
    logic             w_unused;

    feed_state_t      r_state;
    logic             r_auto;
    logic             r_done;
    logic [6:0]       r_len;
    logic [6:0]       r_frame_len;
    logic [5:0]       r_idx;
    logic [GW-1:0]    r_gap_cnt;
    logic [PIX_W-1:0] r_px_data;
    logic             r_px_valid;
    logic             r_px_last;
    logic             r_frame_done;

    assign w_apb_wr    = PSEL & PENABLE & PWRITE;
    assign w_apb_rd    = PSEL & ~PWRITE;
    assign w_pix_we    = w_apb_wr & PADDR[8];
    assign w_wr_ctrl   = w_apb_wr & ~PADDR[8] & (PADDR[7:0] == OFF_CTRL);
    assign w_wr_status = w_apb_wr & ~PADDR[8] & (PADDR[7:0] == OFF_STATUS);
    assign w_wr_len    = w_apb_wr & ~PADDR[8] & (PADDR[7:0] == OFF_LEN);
    assign w_start_req = w_wr_ctrl & PWDATA[CTRL_START_BIT];
    assign w_unused    = &{1'b0, PADDR[31:9], PADDR[1:0]};

    assign w_gap_end     = (r_state == ST_GAP) && (r_gap_cnt == GW'(GAP_CYCLES - 1));
    assign w_frame_start = ((r_state == ST_IDLE) && w_start_req) || (w_gap_end && r_auto);
    // Stream port looks one pixel ahead so a transfer can reload px_data on the same edge.
    assign w_s_addr      = w_frame_start ? 6'd0 : (r_idx + 6'd1);

`ifdef LED_FEED_DOUBLE_BUF_EN
    logic             r_front;
    logic [PIX_W-1:0] w_bank_rdata [2];
    logic [PIX_W-1:0] w_bank_sdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        led_pixel_bank #(
            .DEPTH (NUM_PIXELS),
            .PIX_W (PIX_W)
        ) u_bank (
            .clk     (PCLK),
            .rst_n   (PRESERN),
            .i_we    (w_pix_we && (r_front != 1'(gi))),
            .i_waddr (PADDR[7:2]),
            .i_wdata (PWDATA[PIX_W-1:0]),
            .i_raddr (PADDR[7:2]),
            .o_rdata (w_bank_rdata[gi]),
            .i_saddr (w_s_addr),
            .o_sdata (w_bank_sdata[gi])
        );
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_front <= 1'b0;
        end else if (w_frame_start) begin
            r_front <= ~r_front;
        end
    end

    // The back bank becomes front on the starting edge, so pixel 0 comes from it.
    assign w_front     = r_front;
    assign w_apb_rdata = r_front ? w_bank_rdata[0] : w_bank_rdata[1];
    assign w_s_front   = r_front ? w_bank_sdata[1] : w_bank_sdata[0];
    assign w_s_start   = r_front ? w_bank_sdata[0] : w_bank_sdata[1];
`else
    led_pixel_bank #(
        .DEPTH (NUM_PIXELS),
        .PIX_W (PIX_W)
    ) u_bank (
        .clk     (PCLK),
        .rst_n   (PRESERN),
        .i_we    (w_pix_we),
        .i_waddr (PADDR[7:2]),
        .i_wdata (PWDATA[PIX_W-1:0]),
        .i_raddr (PADDR[7:2]),
        .o_rdata (w_apb_rdata),
        .i_saddr (w_s_addr),
        .o_sdata (w_s_front)
    );

    assign w_front   = 1'b0;
    assign w_s_start = w_s_front;
`endif

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            r_state      <= ST_IDLE;
            r_auto       <= 1'b0;
            r_done       <= 1'b0;
            r_len        <= 7'(NUM_PIXELS);
            r_frame_len  <= 7'(NUM_PIXELS);
            r_idx        <= '0;
            r_gap_cnt    <= '0;
            r_px_data    <= '0;
            r_px_valid   <= 1'b0;
            r_px_last    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_wr_ctrl) begin
                r_auto <= PWDATA[CTRL_AUTO_BIT];
            end
            if (w_wr_len && (PWDATA != 32'd0)) begin
                r_len <= sat_len(PWDATA, NUM_PIXELS);
            end
            if (w_gap_end) begin
                r_done <= 1'b1;
            end else if (w_wr_status && PWDATA[STAT_DONE_BIT]) begin
                r_done <= 1'b0;
            end

            if (w_frame_start) begin
                r_state     <= ST_SEND;
                r_idx       <= '0;
                r_frame_len <= r_len;
                r_px_data   <= w_s_start;
                r_px_valid  <= 1'b1;
                r_px_last   <= (r_len == 7'd1);
            end

            case (r_state)
                ST_IDLE: begin
                end
                ST_SEND: begin
                    if (r_px_valid && px_ready) begin
                        if (r_px_last) begin
                            r_state    <= ST_GAP;
                            r_px_valid <= 1'b0;
                            r_px_last  <= 1'b0;
                            r_gap_cnt  <= '0;
                        end else begin
                            r_idx     <= r_idx + 6'd1;
                            r_px_data <= w_s_front;
                            r_px_last <= (({1'b0, r_idx} + 7'd2) == r_frame_len);
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_frame_done <= 1'b1;
                        if (!r_auto) begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PRDATA = '0;
        if (w_apb_rd) begin
            if (PADDR[8]) begin
                PRDATA[PIX_W-1:0] = w_apb_rdata;
            end else begin
                case (PADDR[7:0])
                    OFF_CTRL: PRDATA[CTRL_AUTO_BIT] = r_auto;
                    OFF_STATUS: begin
                        PRDATA[STAT_BUSY_BIT]  = (r_state != ST_IDLE);
                        PRDATA[STAT_DONE_BIT]  = r_done;
                        PRDATA[STAT_FRONT_BIT] = w_front;
                    end
                    OFF_LEN: PRDATA[6:0] = r_len;
                    default: PRDATA = '0;
                endcase
            end
        end
    end

    assign PREADY     = 1'b1;
    assign PSLVERR    = 1'b0;
    assign px_data    = r_px_data;
    assign px_valid   = r_px_valid;
    assign px_last    = r_px_last;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_frame_feeder.sv
// Scoreboard bench for led_frame_feeder: stimulus queues expected pixels, a monitor checks the stream.
module tb_led_frame_feeder;
    localparam int NPIX = 8;
    localparam int GAP  = 20;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready = 1'b0;
    logic        px_last;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int valid_cycles = 0;
    int drv_cnt  = 0;
    logic prev_valid = 1'b0;
    logic prev_fd    = 1'b0;
    logic stall_mode = 1'b0;
    logic ready_level = 1'b1;
    logic [24:0] exp_q[$];

    led_frame_feeder #(
        .NUM_PIXELS (NPIX),
        .GAP_CYCLES (GAP),
        .PIX_W      (24)
    ) dut (
        .PCLK       (PCLK),
        .PRESERN    (PRESERN),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_last    (px_last),
        .frame_done (frame_done)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ready driver: either a fixed level or a 1-in-3 accept pattern.
    always @(posedge PCLK) begin
        #1;
        drv_cnt++;
        px_ready = stall_mode ? (drv_cnt % 3 == 0) : ready_level;
    end

    // Monitor: pops the scoreboard on every transfer, checks hold during stalls and gap timing.
    always @(negedge PCLK) begin
        logic [24:0] e;
        cyc++;
        if (PRESERN) begin
            if (px_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", 32'd0, 32'd1);
                end else if (px_ready) begin
                    e = exp_q.pop_front();
                    $display("px transfer data=%06h last=%0d", px_data, px_last);
                    chk("px_data", {8'h0, px_data}, {8'h0, e[23:0]});
                    chk("px_last", {31'h0, px_last}, {31'h0, e[24]});
                end else begin
                    e = exp_q[0];
                    chk("stall_data", {8'h0, px_data}, {8'h0, e[23:0]});
                    chk("stall_last", {31'h0, px_last}, {31'h0, e[24]});
                end
            end
            if (prev_valid && !px_valid) fall_cyc = cyc;
            if (frame_done) begin
                $display("frame_done at cycle %0d", cyc);
                chk("fd_width", {31'h0, prev_fd}, 32'd0);
                chk("gap_len", 32'(cyc - fall_cyc), 32'(GAP));
            end
            prev_valid = px_valid;
            prev_fd    = frame_done;
        end else begin
            prev_valid = 1'b0;
            prev_fd    = 1'b0;
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        $display("apb write addr=%03h data=%08h", a, d);
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        $display("apb read  addr=%03h data=%08h", a, d);
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_fd(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge PCLK);
            if (frame_done) seen = 1'b1;
        end
        chk("fd_timeout", {31'h0, seen}, 32'd1);
    endtask

    task automatic push_rgb3();
        exp_q.push_back({1'b0, 24'h00FF00});
        exp_q.push_back({1'b0, 24'hFF0000});
        exp_q.push_back({1'b1, 24'h0000FF});
    endtask

    initial begin
        logic [31:0] d;

        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        PRESERN = 1'b1;
        #1;
        chk("rst_px_valid", {31'h0, px_valid}, 32'd0);
        chk("rst_px_last", {31'h0, px_last}, 32'd0);
        chk("rst_px_data", {8'h0, px_data}, 32'd0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
        chk("pready", {31'h0, PREADY}, 32'd1);
        chk("pslverr", {31'h0, PSLVERR}, 32'd0);
        read_chk("rst_ctrl", 32'h000, 32'd0);
        read_chk("rst_status", 32'h004, 32'd0);
        read_chk("rst_len", 32'h008, NPIX);
        read_chk("rst_pix0", 32'h100, 32'd0);

        // Basic frame: three pixels, ready held high.
        apb_write(32'h100, 32'h0000FF00);
        apb_write(32'h104, 32'h00FF0000);
        apb_write(32'h108, 32'h000000FF);
        apb_write(32'h008, 32'd3);
        read_chk("pix1_rb", 32'h104, 32'h00FF0000);
        apb_write(32'h128, 32'h00ABCDEF);
        read_chk("pix_oob", 32'h128, 32'd0);
        read_chk("undef_off", 32'h00C, 32'd0);
        push_rgb3();
        ready_level = 1'b1;
        valid_cycles = 0;
        apb_write(32'h000, 32'd1);
        chk("valid_after_start", {31'h0, px_valid}, 32'd1);
        wait_fd(200);
        chk("basic_q_empty", exp_q.size(), 32'd0);
        chk("basic_valid_cycles", valid_cycles, 32'd3);
        read_chk("status_done", 32'h004, 32'd2);
        read_chk("ctrl_start_reads0", 32'h000, 32'd0);
        apb_write(32'h004, 32'd2);
        read_chk("status_w1c", 32'h004, 32'd0);

        // Same frame with a 1-in-3 accept pattern.
        push_rgb3();
        stall_mode = 1'b1;
        apb_write(32'h000, 32'd1);
        wait_fd(300);
        chk("stall_q_empty", exp_q.size(), 32'd0);
        stall_mode = 1'b0;

        // START repeated while busy; LEN edge cases.
        ready_level = 1'b0;
        push_rgb3();
        apb_write(32'h000, 32'd1);
        apb_write(32'h000, 32'd1);
        apb_read(32'h004, d);
        chk("busy_during_send", {31'h0, d[0]}, 32'd1);
        apb_write(32'h008, 32'd0);
        read_chk("len_zero_ignored", 32'h008, 32'd3);
        apb_write(32'h008, 32'd200);
        read_chk("len_saturate", 32'h008, NPIX);
        ready_level = 1'b1;
        wait_fd(300);
        valid_cycles = 0;
        repeat (30) @(negedge PCLK);
        chk("single_frame", valid_cycles, 32'd0);
        chk("double_start_q", exp_q.size(), 32'd0);
        apb_read(32'h004, d);
        chk("idle_not_busy", {31'h0, d[0]}, 32'd0);
        apb_write(32'h008, 32'd3);

        // AUTO repeat, then clear AUTO in the middle of the second frame.
        push_rgb3();
        push_rgb3();
        apb_write(32'h000, 32'd3);
        wait_fd(200);
        chk("auto_restart", {31'h0, px_valid}, 32'd1);
        ready_level = 1'b0;
        apb_write(32'h000, 32'd0);
        apb_read(32'h004, d);
        chk("auto_busy", {31'h0, d[0]}, 32'd1);
        ready_level = 1'b1;
        wait_fd(200);
        chk("no_restart", {31'h0, px_valid}, 32'd0);
        valid_cycles = 0;
        repeat (30) @(negedge PCLK);
        chk("auto_stopped", valid_cycles, 32'd0);
        chk("auto_q_empty", exp_q.size(), 32'd0);
        apb_read(32'h004, d);
        chk("auto_idle", {31'h0, d[0]}, 32'd0);

        // Asynchronous reset in the middle of a stalled frame.
        ready_level = 1'b0;
        push_rgb3();
        apb_write(32'h000, 32'd1);
        repeat (2) @(negedge PCLK);
        #2;
        PRESERN = 1'b0;
        #1;
        chk("async_rst_valid", {31'h0, px_valid}, 32'd0);
        exp_q.delete();
        @(posedge PCLK);
        @(negedge PCLK);
        PRESERN = 1'b1;
        ready_level = 1'b1;
        read_chk("post_rst_len", 32'h008, NPIX);
        read_chk("post_rst_status", 32'h004, 32'd0);
        read_chk("post_rst_ctrl", 32'h000, 32'd0);
        read_chk("post_rst_pix0", 32'h100, 32'd0);
        read_chk("post_rst_pix2", 32'h108, 32'd0);

`ifdef LED_FEED_DOUBLE_BUF_EN
        // Back-bank writes during a frame do not disturb the streamed pixel.
        apb_write(32'h008, 32'd1);
        apb_write(32'h100, 32'h00AAAAAA);
        ready_level = 1'b0;
        exp_q.push_back({1'b1, 24'hAAAAAA});
        apb_write(32'h000, 32'd1);
        apb_read(32'h004, d);
        chk("db_front1", {31'h0, d[2]}, 32'd1);
        apb_write(32'h100, 32'h00123456);
        ready_level = 1'b1;
        wait_fd(200);
        exp_q.push_back({1'b1, 24'h123456});
        apb_write(32'h000, 32'd1);
        apb_read(32'h004, d);
        chk("db_front0", {31'h0, d[2]}, 32'd0);
        wait_fd(200);
        chk("db_q_empty", exp_q.size(), 32'd0);
`endif

        repeat (5) @(negedge PCLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
